// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the default memory depth.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRITE  = 2'd2
    } state_e;

    localparam int unsigned MEM_WORDS_DEF = 64;

endpackage

// File: rtl/lsu_lane.sv
// Little-endian lane handling: extract + sign/zero extend for loads and
// read-modify-write lane merge for sub-word stores.
module lsu_lane
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        sgn,
    input  logic [31:0] rd,
    input  logic [31:0] wd,
    output logic [31:0] ld_data,
    output logic [31:0] st_merge
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b   = rd[{addr_lo, 3'b000} +: 8];
        lane_h   = rd[{addr_lo[1], 4'b0000} +: 16];
        ld_data  = rd;
        st_merge = wd;
        case (size)
            SZ_BYTE: begin
                ld_data  = {{24{sgn & lane_b[7]}}, lane_b};
                st_merge = rd;
                st_merge[{addr_lo, 3'b000} +: 8] = wd[7:0];
            end
            SZ_HALF: begin
                ld_data  = {{16{sgn & lane_h[15]}}, lane_h};
                st_merge = rd;
                st_merge[{addr_lo[1], 4'b0000} +: 16] = wd[15:0];
            end
            default: begin
                ld_data  = rd;
                st_merge = wd;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store initiator for a word-addressed memory with
// asynchronous read and synchronous write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        st,
    input  logic [1:0]  size,
    input  logic        sgn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        done,
    output logic        err,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic        st_q, st_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] merge_q, merge_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        req_bad;
    logic [31:0] ld_data;
    logic [31:0] st_merge;

    lsu_lane u_lane (
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .sgn      (sgn_q),
        .rd       (mem_rd),
        .wd       (wdata_q),
        .ld_data  (ld_data),
        .st_merge (st_merge)
    );

    // Checked on the raw request so a rejected access never leaves IDLE.
    always_comb begin
        req_bad = (size == SZ_RSVD)
                | ((size == SZ_HALF) & addr[0])
                | ((size == SZ_WORD) & (addr[1:0] != 2'b00))
                | ({2'b00, addr[31:2]} >= MEM_WORDS);
    end

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    st_d    = st;
                    size_d  = size;
                    sgn_d   = sgn;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (req_bad) begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (!st_q) begin
                    rdata_d = ld_data;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (size_q == SZ_WORD) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    merge_d = st_merge;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            st_q    <= 1'b0;
            size_q  <= '0;
            sgn_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            merge_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Write enable comes straight from registered state so reset drops it at once.
    always_comb begin
        mem_we = (state_q == WRITE)
               | ((state_q == ACCESS) & st_q & (size_q == SZ_WORD));
        mem_wd = (state_q == WRITE) ? merge_q : wdata_q;
    end

    assign mem_a = {2'b00, addr_q[31:2]};
    assign rdata = rdata_q;
    assign done  = done_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a 64-word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, st, sgn;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [31:0] rdata, mem_a, mem_wd, mem_rd;
    logic        done, err, busy, mem_we;

    logic [31:0] mem [0:63];

    typedef struct {
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   we_cnt = 0;
    int   busy_cnt = 0;
    logic [31:0] last_rd = '0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_WORDS(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .st     (st),
        .size   (size),
        .sgn    (sgn),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .done   (done),
        .err    (err),
        .busy   (busy),
        .mem_we (mem_we),
        .mem_a  (mem_a),
        .mem_wd (mem_wd),
        .mem_rd (mem_rd)
    );

    assign mem_rd = (mem_a < 32'd64) ? mem[mem_a[5:0]] : '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we && mem_a < 32'd64) mem[mem_a[5:0]] <= mem_wd;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (busy) busy_cnt++;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_err", {31'd0, err}, {31'd0, e.e_err});
                check("done_rdata", rdata, e.e_rdata);
                check("done_cycle", cyc, e.e_cyc);
            end
        end
    end

    task automatic issue(input logic i_st, input logic [1:0] i_size, input logic i_sgn,
                         input logic [31:0] i_addr, input logic [31:0] i_wdata,
                         input int lat, input logic e_err, input logic [31:0] e_rd);
        exp_t e;
        int guard = 0;
        while (busy && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req = 1'b1; st = i_st; size = i_size; sgn = i_sgn; addr = i_addr; wdata = i_wdata;
        if (!i_st && !e_err) last_rd = e_rd;
        e.e_err = e_err; e.e_rdata = last_rd; e.e_cyc = cyc + lat;
        sb.push_back(e);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (sb.size() != 0 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (sb.size() != 0) begin
            check("timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic op(input string name, input logic i_st, input logic [1:0] i_size,
                      input logic i_sgn, input logic [31:0] i_addr, input logic [31:0] i_wdata,
                      input int lat, input logic e_err, input logic [31:0] e_rd, input int e_we);
        int we0, busy0;
        we0 = we_cnt; busy0 = busy_cnt;
        issue(i_st, i_size, i_sgn, i_addr, i_wdata, lat, e_err, e_rd);
        wait_idle();
        check({name, "_we_cycles"}, 32'(we_cnt - we0), 32'(e_we));
        if (e_err) check({name, "_busy_cycles"}, 32'(busy_cnt - busy0), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[1] = 32'h8899AABB;
        reset = 1'b1; req = 1'b0; st = 1'b0; size = 2'b00; sgn = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Loads from word1 = 0x8899AABB
        op("ld_w",    1'b0, 2'b10, 1'b0, 32'h4, '0, 2, 1'b0, 32'h8899AABB, 0);
        op("ld_b_s",  1'b0, 2'b00, 1'b1, 32'h7, '0, 2, 1'b0, 32'hFFFFFF88, 0);
        op("ld_b_u",  1'b0, 2'b00, 1'b0, 32'h7, '0, 2, 1'b0, 32'h00000088, 0);
        op("ld_h_s",  1'b0, 2'b01, 1'b1, 32'h4, '0, 2, 1'b0, 32'hFFFFAABB, 0);
        op("ld_h_u",  1'b0, 2'b01, 1'b0, 32'h6, '0, 2, 1'b0, 32'h00008899, 0);

        // Stores
        op("st_b",    1'b1, 2'b00, 1'b0, 32'h5, 32'h11223344, 3, 1'b0, '0, 1);
        check("st_b_mem", mem[1], 32'h889944BB);
        op("st_w",    1'b1, 2'b10, 1'b0, 32'h4, 32'hDEADBEEF, 2, 1'b0, '0, 1);
        check("st_w_mem", mem[1], 32'hDEADBEEF);

        // Rejected requests
        op("e_w_mis", 1'b1, 2'b10, 1'b0, 32'h6,   32'h12345678, 1, 1'b1, '0, 0);
        op("e_h_mis", 1'b0, 2'b01, 1'b0, 32'h3,   '0,           1, 1'b1, '0, 0);
        op("e_rsvd",  1'b1, 2'b11, 1'b0, 32'h0,   32'hCAFEF00D, 1, 1'b1, '0, 0);
        op("e_range", 1'b1, 2'b10, 1'b0, 32'h100, 32'h0BADF00D, 1, 1'b1, '0, 0);
        check("err_mem0", mem[0], 32'h0);
        check("err_mem1", mem[1], 32'hDEADBEEF);

        // req held high: first load accepted, busy-time req ignored, reaccepted in done cycle
        begin
            exp_t e;
            int we0;
            we0 = we_cnt;
            req = 1'b1; st = 1'b0; size = 2'b10; sgn = 1'b0; addr = 32'h4;
            e.e_err = 1'b0; e.e_rdata = 32'hDEADBEEF; e.e_cyc = cyc + 2;
            sb.push_back(e);
            @(posedge clk); #1;
            size = 2'b00; addr = 32'h5;
            e.e_err = 1'b0; e.e_rdata = 32'h000000BE; e.e_cyc = cyc + 3;
            sb.push_back(e);
            repeat (3) @(posedge clk);
            #1;
            req = 1'b0;
            last_rd = 32'h000000BE;
            wait_idle();
            check("b2b_we_cycles", 32'(we_cnt - we0), 32'd0);
        end

        // Reset in the middle of a sub-word store's WRITE cycle
        issue(1'b1, 2'b00, 1'b0, 32'h8, 32'h000000AB, 3, 1'b0, '0);
        @(posedge clk); #1;
        check("pre_rst_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_we", {31'd0, mem_we}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        sb.delete();
        last_rd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem2", mem[2], 32'h0);
        reset = 1'b0;
        check("rst_rdata2", rdata, 32'h0);
        @(posedge clk); #1;
        op("post_rst", 1'b0, 2'b10, 1'b0, 32'h4, '0, 2, 1'b0, 32'hDEADBEEF, 0);

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
